// File: rtl/pipeline_if_stage5.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_if_stage5
// Brief    : Instruction-fetch stage. Owns the fetch PC and runs a single-
//            outstanding req/gnt/rvalid handshake to instruction memory. It
//            feeds the IF/ID register and honours branch redirects from EXB
//            by killing in-flight or buffered instructions and pulsing flush.
// Options  : IF_MISALIGN_CHK_EN - a misaligned redirect target raises a
//            sticky fetch_misalign and parks the FSM in HALT until reset.
//            When it is undefined, target bits [1:0] are forced to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_if_stage5 #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken_EXB,
   input  logic [63:0] branch_target_EXB,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [63:0] pc_IF,
   output logic [31:0] inst_IF,
   output logic        valid_IF,
   output logic        flush_IF,
   output logic        fetch_misalign
);

`ifdef IF_MISALIGN_CHK_EN
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;
`endif

   localparam logic [63:0] c_PC_STEP = 64'd4;

   state_t      r_state;
   logic [63:0] r_fetch_pc;
   logic        r_kill;
   logic [63:0] r_skid_pc;
   logic [31:0] r_skid_inst;
   logic [63:0] r_pc_if;
   logic [31:0] r_inst_if;
   logic        r_valid_if;
   logic [63:0] w_target;

`ifdef IF_MISALIGN_CHK_EN
   logic        r_misalign;
   logic        w_misalign;

   // A taken branch to a non-word-aligned address is an error, not a redirect
   assign w_target       = branch_target_EXB;
   assign w_misalign     = branch_taken_EXB & (|branch_target_EXB[1:0]);
   assign fetch_misalign = r_misalign;
`else
   logic        w_unused_lsb;

   // Without the checker the low bits are simply dropped
   assign w_target       = {branch_target_EXB[63:2], 2'b00};
   assign w_unused_lsb   = ^branch_target_EXB[1:0];
   assign fetch_misalign = 1'b0;
`endif

   // Requests only go out from REQ and never while reset is held
   assign imem_req  = (r_state == S_REQ) & reset;
   assign imem_addr = r_fetch_pc;
   assign flush_IF  = branch_taken_EXB;
   assign pc_IF     = r_pc_if;
   assign inst_IF   = r_inst_if;
   assign valid_IF  = r_valid_if;

   // Fetch FSM, fetch PC, skid buffer and IF/ID register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_REQ;
         r_fetch_pc  <= RESET_PC;
         r_kill      <= 1'b0;
         r_skid_pc   <= 64'd0;
         r_skid_inst <= 32'd0;
         r_pc_if     <= 64'd0;
         r_inst_if   <= NOP_INST;
         r_valid_if  <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         // Redirect squashes IF/ID even under stall; an unstalled idle cycle
         // leaves a bubble; a stalled cycle keeps the register as it is.
         if (branch_taken_EXB || !stall) begin
            r_valid_if <= 1'b0;
            r_inst_if  <= NOP_INST;
         end

         case (r_state)
            S_REQ: begin
               if (branch_taken_EXB)
                  r_fetch_pc <= w_target;
               if (imem_gnt) begin
                  r_state <= S_WAIT;
                  // Granted request was for the old PC, so its data is dead
                  r_kill  <= branch_taken_EXB;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (r_kill || branch_taken_EXB) begin
                     r_kill  <= 1'b0;
                     r_state <= S_REQ;
                     if (branch_taken_EXB)
                        r_fetch_pc <= w_target;
                  end else if (!stall) begin
                     r_pc_if    <= r_fetch_pc;
                     r_inst_if  <= imem_rdata;
                     r_valid_if <= 1'b1;
                     r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                     r_state    <= S_REQ;
                  end else begin
                     r_skid_pc   <= r_fetch_pc;
                     r_skid_inst <= imem_rdata;
                     r_state     <= S_HOLD;
                  end
               end else if (branch_taken_EXB) begin
                  // Response still owed; remember to drop it when it lands
                  r_fetch_pc <= w_target;
                  r_kill     <= 1'b1;
               end
            end
            S_HOLD: begin
               if (branch_taken_EXB) begin
                  r_fetch_pc <= w_target;
                  r_state    <= S_REQ;
               end else if (!stall) begin
                  r_pc_if    <= r_skid_pc;
                  r_inst_if  <= r_skid_inst;
                  r_valid_if <= 1'b1;
                  r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                  r_state    <= S_REQ;
               end
            end
`ifdef IF_MISALIGN_CHK_EN
            S_HALT: begin
               r_state <= S_HALT;
            end
`endif
            default: begin
               r_state <= S_REQ;
            end
         endcase

`ifdef IF_MISALIGN_CHK_EN
         // Misaligned redirect overrides everything and parks the stage
         if (w_misalign) begin
            r_misalign <= 1'b1;
            r_valid_if <= 1'b0;
            r_inst_if  <= NOP_INST;
            r_kill     <= 1'b0;
            r_state    <= S_HALT;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_if_stage5.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_if_stage5
// Brief    : Directed bench for pipeline_if_stage5 (default build). Memory
//            handshake is driven step by step from a single initial block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_if_stage5;

   localparam logic [31:0] c_NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken_EXB;
   logic [63:0] branch_target_EXB;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [63:0] pc_IF;
   logic [31:0] inst_IF;
   logic        valid_IF;
   logic        flush_IF;
   logic        fetch_misalign;

   int tests_run;
   int tests_failed;

   pipeline_if_stage5 dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .branch_taken_EXB  (branch_taken_EXB),
      .branch_target_EXB (branch_target_EXB),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_gnt          (imem_gnt),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .pc_IF             (pc_IF),
      .inst_IF           (inst_IF),
      .valid_IF          (valid_IF),
      .flush_IF          (flush_IF),
      .fetch_misalign    (fetch_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Grant in REQ, respond one cycle later with no stall
   task automatic fetch_one(input logic [31:0] data);
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      tick();
      imem_rvalid = 1'b0;
   endtask

   initial begin
      tests_run         = 0;
      tests_failed      = 0;
      reset             = 1'b0;
      stall             = 1'b0;
      branch_taken_EXB  = 1'b0;
      branch_target_EXB = 64'd0;
      imem_gnt          = 1'b0;
      imem_rvalid       = 1'b0;
      imem_rdata        = 32'd0;

      // ---- reset state ----
      tick();
      tick();
      chk("rst_valid", valid_IF, 1'b0);
      chk("rst_inst", inst_IF, c_NOP);
      chk("rst_pc", pc_IF, 64'd0);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 64'h8000_0000);
      chk("rst_misalign", fetch_misalign, 1'b0);
      reset = 1'b1;
      #1;
      chk("req_after_rst", imem_req, 1'b1);

      // ---- straight-line fetch ----
      fetch_one(32'h1111_0001);
      chk("f0_pc", pc_IF, 64'h8000_0000);
      chk("f0_inst", inst_IF, 32'h1111_0001);
      chk("f0_valid", valid_IF, 1'b1);
      chk("f0_next_addr", imem_addr, 64'h8000_0004);
      fetch_one(32'h1111_0002);
      chk("f1_pc", pc_IF, 64'h8000_0004);
      chk("f1_inst", inst_IF, 32'h1111_0002);
      fetch_one(32'h1111_0003);
      chk("f2_pc", pc_IF, 64'h8000_0008);
      chk("f2_inst", inst_IF, 32'h1111_0003);

      // ---- stall while response arrives: HOLD ----
      imem_gnt = 1'b1;
      tick();
      chk("bubble_valid", valid_IF, 1'b0);
      chk("wait_no_req", imem_req, 1'b0);
      imem_gnt    = 1'b0;
      stall       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h2222_0004;
      tick();
      imem_rvalid = 1'b0;
      chk("hold_req", imem_req, 1'b0);
      chk("hold_pc", pc_IF, 64'h8000_0008);
      chk("hold_valid", valid_IF, 1'b0);
      tick();
      tick();
      chk("hold3_req", imem_req, 1'b0);
      stall = 1'b0;
      tick();
      chk("skid_pc", pc_IF, 64'h8000_000C);
      chk("skid_inst", inst_IF, 32'h2222_0004);
      chk("skid_valid", valid_IF, 1'b1);
      chk("skid_next_addr", imem_addr, 64'h8000_0010);
      chk("skid_next_req", imem_req, 1'b1);

      // ---- redirect in the grant cycle ----
      imem_gnt          = 1'b1;
      branch_taken_EXB  = 1'b1;
      branch_target_EXB = 64'h8000_0100;
      #1;
      chk("gnt_redir_flush", flush_IF, 1'b1);
      tick();
      imem_gnt         = 1'b0;
      branch_taken_EXB = 1'b0;
      chk("gnt_redir_valid", valid_IF, 1'b0);
      chk("gnt_redir_flush_low", flush_IF, 1'b0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      chk("killed_valid", valid_IF, 1'b0);
      chk("killed_inst", inst_IF, c_NOP);
      chk("redir_addr", imem_addr, 64'h8000_0100);
      chk("redir_req", imem_req, 1'b1);

      // ---- redirect while holding a stalled instruction ----
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      stall       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h3333_0005;
      tick();
      imem_rvalid = 1'b0;
      chk("hold2_req", imem_req, 1'b0);
      branch_taken_EXB  = 1'b1;
      branch_target_EXB = 64'h8000_0200;
      tick();
      branch_taken_EXB = 1'b0;
      stall            = 1'b0;
      chk("drop_skid_valid", valid_IF, 1'b0);
      chk("drop_skid_addr", imem_addr, 64'h8000_0200);
      chk("drop_skid_req", imem_req, 1'b1);

      // ---- misaligned target, checker disabled: low bits dropped ----
      branch_taken_EXB  = 1'b1;
      branch_target_EXB = 64'h8000_0102;
      tick();
      branch_taken_EXB = 1'b0;
      chk("misal_addr", imem_addr, 64'h8000_0100);
      chk("misal_flag", fetch_misalign, 1'b0);
      chk("misal_req", imem_req, 1'b1);

      // ---- PC wrap at top of address space ----
      branch_taken_EXB  = 1'b1;
      branch_target_EXB = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      branch_taken_EXB = 1'b0;
      chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      fetch_one(32'h4444_0006);
      chk("wrap_pc", pc_IF, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_inst", inst_IF, 32'h4444_0006);
      chk("wrap_next_addr", imem_addr, 64'd0);

      // ---- asynchronous reset mid-WAIT ----
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_pc", pc_IF, 64'd0);
      chk("arst_valid", valid_IF, 1'b0);
      chk("arst_inst", inst_IF, c_NOP);
      chk("arst_req", imem_req, 1'b0);
      chk("arst_addr", imem_addr, 64'h8000_0000);
      tick();
      reset = 1'b1;

      // Stale response arriving in REQ after reset must be ignored
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      tick();
      imem_rvalid = 1'b0;
      chk("stale_valid", valid_IF, 1'b0);
      chk("stale_addr", imem_addr, 64'h8000_0000);
      fetch_one(32'h5555_0007);
      chk("post_rst_pc", pc_IF, 64'h8000_0000);
      chk("post_rst_inst", inst_IF, 32'h5555_0007);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
